// File: rtl/addsub_result_checker.sv
// Response checker for an adder/subtractor: recomputes the golden sum, carry vector
// and overflow in a two-stage pipeline and scores each returned beat.
module addsub_result_checker #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned HALT_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_ovf,
    output logic             res_valid,
    output logic [2:0]       res_err,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             fail_sticky,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic             first_fail_cin,
    output logic             halted
);

    localparam bit               HALT_EN = (HALT_ON_FAIL != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_s;
    logic [WIDTH-1:0] s1_c;
    logic             s1_ovf;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s_exp;
    logic [WIDTH-1:0] c_exp;
    logic             ovf_exp;
    logic [2:0]       err_c;
    logic             fail_rec;
    logic             accept;

    // Golden ripple-carry model on the stage-1 operands
    always_comb begin
        logic k;
        b_eff = s1_cin ? ~s1_b : s1_b;
        s_exp = '0;
        c_exp = '0;
        k     = s1_cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s_exp[i] = s1_a[i] ^ b_eff[i] ^ k;
            k        = (s1_a[i] & b_eff[i]) | (s1_a[i] & k) | (b_eff[i] & k);
            c_exp[i] = k;
        end
        ovf_exp = c_exp[WIDTH-1] ^ c_exp[WIDTH-2];
    end

    assign err_c    = {ovf_exp != s1_ovf, c_exp != s1_c, s_exp != s1_s};
    assign fail_rec = s1_valid && (err_c != 3'b000);

    // Backpressure drops combinationally so no beat is taken behind a halting fail
    assign in_ready = !rst && (state == ST_RUN) && !(HALT_EN && fail_rec);
    assign accept   = in_valid && in_ready;
    assign halted   = (state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_RUN && HALT_EN && fail_rec) begin
            state_nxt = ST_HALT;
        end
        if (clear) begin
            state_nxt = ST_RUN;
        end
    end

    // Stage 1: operand and returned-result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_s     <= '0;
            s1_c     <= '0;
            s1_ovf   <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_cin <= in_cin;
                s1_s   <= in_s;
                s1_c   <= in_c;
                s1_ovf <= in_ovf;
            end
        end
    end

    // Stage 2: result pulse and mismatch mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_err   <= 3'b000;
        end else if (clear) begin
            res_valid <= 1'b0;
            res_err   <= 3'b000;
        end else begin
            res_valid <= s1_valid;
            res_err   <= s1_valid ? err_c : 3'b000;
        end
    end

    // Saturating scoreboard counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (clear) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (s1_valid) begin
            if (err_c != 3'b000) begin
                if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
            end else if (pass_count != CNT_MAX) begin
                pass_count <= pass_count + CNT_W'(1);
            end
        end
    end

    // First-failure capture, armed until the sticky flag is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_sticky    <= 1'b0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_cin <= 1'b0;
        end else if (clear) begin
            fail_sticky    <= 1'b0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_cin <= 1'b0;
        end else if (fail_rec && !fail_sticky) begin
            fail_sticky    <= 1'b1;
            first_fail_a   <= s1_a;
            first_fail_b   <= s1_b;
            first_fail_cin <= s1_cin;
        end
    end

endmodule

// File: tb/tb_addsub_result_checker.sv
// Scoreboard bench for addsub_result_checker: default, halt-on-fail and
// narrow-counter instances share one stimulus bus.
module tb_addsub_result_checker;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic [2:0]   valid;
    logic [W-1:0] a, b, s, c;
    logic         cin, ovf;

    logic         rdy0, rv0, sticky0, ffc0, halt0;
    logic [2:0]   err0;
    logic [15:0]  pass0, fail0;
    logic [W-1:0] ffa0, ffb0;

    logic         rdy1, rv1, sticky1, ffc1, halt1;
    logic [2:0]   err1;
    logic [15:0]  pass1, fail1;
    logic [W-1:0] ffa1, ffb1;

    logic         rdy2, rv2, sticky2, ffc2, halt2;
    logic [2:0]   err2;
    logic [1:0]   pass2, fail2;
    logic [W-1:0] ffa2, ffb2;

    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] sbq[$];
    int         sel = 0;
    int         rv_cnt = 0;
    int         run = 0;
    int         max_run = 0;
    int         cyc = 0;

    addsub_result_checker #(.WIDTH(W), .CNT_W(16), .HALT_ON_FAIL(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(valid[0]), .in_ready(rdy0),
        .in_a(a), .in_b(b), .in_cin(cin), .in_s(s), .in_c(c), .in_ovf(ovf),
        .res_valid(rv0), .res_err(err0), .pass_count(pass0), .fail_count(fail0),
        .fail_sticky(sticky0), .first_fail_a(ffa0), .first_fail_b(ffb0),
        .first_fail_cin(ffc0), .halted(halt0));

    addsub_result_checker #(.WIDTH(W), .CNT_W(16), .HALT_ON_FAIL(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(valid[1]), .in_ready(rdy1),
        .in_a(a), .in_b(b), .in_cin(cin), .in_s(s), .in_c(c), .in_ovf(ovf),
        .res_valid(rv1), .res_err(err1), .pass_count(pass1), .fail_count(fail1),
        .fail_sticky(sticky1), .first_fail_a(ffa1), .first_fail_b(ffb1),
        .first_fail_cin(ffc1), .halted(halt1));

    addsub_result_checker #(.WIDTH(W), .CNT_W(2), .HALT_ON_FAIL(0)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(valid[2]), .in_ready(rdy2),
        .in_a(a), .in_b(b), .in_cin(cin), .in_s(s), .in_c(c), .in_ovf(ovf),
        .res_valid(rv2), .res_err(err2), .pass_count(pass2), .fail_count(fail2),
        .fail_sticky(sticky2), .first_fail_a(ffa2), .first_fail_b(ffb2),
        .first_fail_cin(ffc2), .halted(halt2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result {ovf, carry vector, sum} from per-prefix additions
    function automatic logic [16:0] golden(input logic [7:0] ga, input logic [7:0] gb,
                                           input logic gcin);
        logic [7:0] be, m, sum, cv;
        logic [8:0] tot;
        logic       ov;
        be  = gcin ? ~gb : gb;
        sum = 8'(ga + be + 8'(gcin));
        for (int i = 0; i < 8; i++) begin
            m     = 8'((9'h1 << (i + 1)) - 9'h1);
            tot   = {1'b0, ga & m} + {1'b0, be & m} + 9'(gcin);
            cv[i] = tot[i+1];
        end
        ov = (ga[7] == be[7]) && (sum[7] != ga[7]);
        return {ov, cv, sum};
    endfunction

    function automatic logic sel_ready();
        return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
    endfunction

    // Present a beat (golden result XORed with corruption masks); starts and ends on a negedge
    task automatic push(input logic [7:0] pa, input logic [7:0] pb, input logic pcin,
                        input logic [7:0] sx, input logic [7:0] cx, input logic ox,
                        input int bound, output bit acc);
        logic [16:0] g;
        g     = golden(pa, pb, pcin);
        a     = pa;
        b     = pb;
        cin   = pcin;
        s     = g[7:0] ^ sx;
        c     = g[15:8] ^ cx;
        ovf   = g[16] ^ ox;
        valid = 3'(3'b001 << sel);
        acc   = 1'b0;
        for (int i = 0; i < bound && !acc; i++) begin
            #1;
            if (sel_ready()) begin
                acc = 1'b1;
                if (sel == 0 && !clear) sbq.push_back({ox, cx != 8'h00, sx != 8'h00});
            end
            @(negedge clk);
        end
    endtask

    task automatic do_clear();
        valid = 3'b000;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sbq.delete();
    endtask

    always @(negedge clk) begin
        if (rv0) begin
            rv_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (sbq.size() == 0) check("rv_unexpected", 1, 0);
            else check("res_err", err0, sbq.pop_front());
        end else begin
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int c0, rv0_start;
        rst   = 1'b1;
        clear = 1'b0;
        valid = 3'b000;
        a = '0; b = '0; s = '0; c = '0; cin = 1'b0; ovf = 1'b0;

        #12;
        check("rst_ready", rdy0, 0);
        check("rst_pass", pass0, 0);
        check("rst_sticky", sticky0, 0);
        check("rst_halted", halt1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", rdy0, 1);

        // FF + 01: correct beat, latency
        push(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 20, acc);
        check("acc_t1", acc, 1);
        valid = 3'b000;
        check("lat_early", rv0, 0);
        @(negedge clk);
        check("lat_rv", rv0, 1);
        @(negedge clk);
        check("t1_pass", pass0, 1);
        check("t1_fail", fail0, 0);

        // 7F + 01 signed overflow, then overflow flag wrong
        push(8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 20, acc);
        check("acc_t2a", acc, 1);
        push(8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 20, acc);
        check("acc_t2b", acc, 1);
        valid = 3'b000;
        repeat (3) @(negedge clk);
        check("t2_pass", pass0, 2);
        check("t2_fail", fail0, 1);
        check("t2_sticky", sticky0, 1);

        do_clear();
        check("clr_pass", pass0, 0);
        check("clr_fail", fail0, 0);
        check("clr_sticky", sticky0, 0);

        // Subtract with wrong sum, then a later fail must not move the capture
        push(8'h80, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0, 20, acc);
        check("acc_t3a", acc, 1);
        push(8'h55, 8'h12, 1'b0, 8'h00, 8'h04, 1'b0, 20, acc);
        check("acc_t3b", acc, 1);
        valid = 3'b000;
        repeat (3) @(negedge clk);
        check("t3_ffa", ffa0, 32'h80);
        check("t3_ffb", ffb0, 32'h01);
        check("t3_ffcin", ffc0, 1);
        check("t3_fail", fail0, 2);
        check("t3_pass", pass0, 0);

        // In-flight beat and a beat accepted on the clear edge are both dropped
        push(8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 20, acc);
        clear = 1'b1;
        push(8'h56, 8'h78, 1'b1, 8'h00, 8'h00, 1'b0, 20, acc);
        clear = 1'b0;
        valid = 3'b000;
        sbq.delete();
        repeat (3) @(negedge clk);
        check("clracc_pass", pass0, 0);
        check("clracc_fail", fail0, 0);
        check("clracc_ffa", ffa0, 0);

        // Eight back-to-back beats
        rv0_start = rv_cnt;
        max_run   = 0;
        c0        = cyc;
        for (int i = 0; i < 8; i++) begin
            push(8'($urandom), 8'($urandom), 1'($urandom), 8'h00, 8'h00, 1'b0, 20, acc);
            check("acc_b2b", acc, 1);
        end
        check("tput_cycles", cyc - c0, 8);
        valid = 3'b000;
        repeat (4) @(negedge clk);
        check("b2b_pulses", rv_cnt - rv0_start, 8);
        check("b2b_run", max_run, 8);
        check("b2b_pass", pass0, 8);

        // Halt-on-fail instance
        sel = 1;
        push(8'h6C, 8'hCA, 1'b1, 8'h00, 8'h00, 1'b0, 20, acc);
        check("acc_h1", acc, 1);
        push(8'hDD, 8'h09, 1'b1, 8'h00, 8'h01, 1'b0, 20, acc);
        check("acc_h2", acc, 1);
        #1 check("halt_rdy_drop", rdy1, 0);
        push(8'hEF, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0, 6, acc);
        check("halt_ef_rejected", acc, 0);
        valid = 3'b000;
        check("halt_halted", halt1, 1);
        check("halt_pass", pass1, 1);
        check("halt_fail", fail1, 1);
        check("halt_ready", rdy1, 0);
        do_clear();
        #1;
        check("halt_clr_ready", rdy1, 1);
        check("halt_clr_halted", halt1, 0);
        check("halt_clr_pass", pass1, 0);
        check("halt_clr_fail", fail1, 0);
        @(negedge clk);

        // Two-bit counter saturation
        sel = 2;
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom), 8'($urandom), 1'($urandom), 8'h00, 8'h00, 1'b0, 20, acc);
            check("acc_sat", acc, 1);
        end
        valid = 3'b000;
        repeat (3) @(negedge clk);
        check("sat_pass", pass2, 3);
        check("sat_fail", fail2, 0);

        // Asynchronous reset with two beats in flight
        sel = 0;
        push(8'h21, 8'h43, 1'b0, 8'h00, 8'h00, 1'b0, 20, acc);
        valid = 3'b000;
        repeat (3) @(negedge clk);
        check("pre_rst_pass", pass0, 1);
        push(8'h3C, 8'h0F, 1'b1, 8'h00, 8'h00, 1'b0, 20, acc);
        check("acc_r1", acc, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", rdy0, 0);
        check("arst_rv", rv0, 0);
        check("arst_pass", pass0, 0);
        check("arst_fail", fail0, 0);
        check("arst_misc", {ffa0, ffb0, ffc0, sticky0, halt0, err0}, 0);
        sbq.delete();
        valid = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_pass", pass0, 0);
        push(8'hA5, 8'h5A, 1'b1, 8'h00, 8'h00, 1'b0, 20, acc);
        check("acc_r2", acc, 1);
        valid = 3'b000;
        repeat (3) @(negedge clk);
        check("post_rst_beat_pass", pass0, 1);
        check("post_rst_beat_fail", fail0, 0);

        check("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addsub_result_checker.md
Name: addsub_result_checker

Overview:
Hardware response checker for the 8-bit adder/subtractor, at the receiving end of the operand/result interface that the stimulus side drives. Each beat carries operands a, b, cin and the unit's returned sum, carry vector and overflow flag. The block recomputes the golden result in a two-stage pipeline, compares it with the returned result, and keeps pass/fail counters, a sticky fail flag and a capture of the first failing beat. It is used in self-checking hardware test harnesses.

Parameters:
WIDTH, 8, operand/sum/carry width in bits
CNT_W, 16, width of pass and fail counters (saturating)
HALT_ON_FAIL, 0, 1 = stop accepting beats after the first mismatch until clear

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous clear of counters, sticky flag, capture and HALT state
in_valid  input  1  beat present on in_* this cycle
in_ready  output  1  checker can accept a beat this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_cin  input  1  0 = add (a+b), 1 = subtract (a+~b+1)
in_s  input  WIDTH  returned sum
in_c  input  WIDTH  returned carry vector, c[i] = carry out of bit i
in_ovf  input  1  returned overflow
res_valid  output  1  one-cycle pulse, check result for one beat
res_err  output  3  mismatch mask {ovf, carry, sum}; valid with res_valid
pass_count  output  CNT_W  beats with all fields matching
fail_count  output  CNT_W  beats with any mismatch
fail_sticky  output  1  set on the first mismatch, held until clear/rst
first_fail_a  output  WIDTH  in_a of first failing beat
first_fail_b  output  WIDTH  in_b of first failing beat
first_fail_cin  output  1  in_cin of first failing beat
halted  output  1  high in HALT state

Behaviour:
- Reset (async, rst=1): all outputs and internal registers are 0, state = RUN, and both pipeline stages are empty. in_ready=0 while rst is high. Reset mid-stream discards in-flight beats; no res_valid is emitted for them.
- Handshake: a beat is accepted on a rising edge where in_valid && in_ready. in_* must be held stable while in_valid=1 && in_ready=0. Throughput is one beat per cycle.
- Golden model, stage 1, from registered operands:
  - b_eff = cin ? ~b : b
  - ripple carry with carry-in = cin: s_exp[i] = a[i]^b_eff[i]^k[i]; c_exp[i] = maj(a[i], b_eff[i], k[i]); k[0]=cin, k[i+1]=c_exp[i]
  - ovf_exp = c_exp[WIDTH-1] ^ c_exp[WIDTH-2]
- Stage 2 registers:
  - res_err = {ovf≠, c≠, s≠}
  - res_valid = 1 for exactly one cycle
- Latency: beat accepted at edge k gives res_valid high during the cycle after edge k+1. The counters and first-fail capture are updated at that same edge k+1.
- Counters:
  - pass_count += 1 when res_err == 0; fail_count += 1 otherwise.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- First-fail capture is loaded only when fail_sticky=0 and a mismatch is recorded; fail_sticky is set at the same edge.
- States:
  - RUN: in_ready=1. This holds unless HALT_ON_FAIL=1 and stage 1 holds a mismatching beat; in that case in_ready=0 combinationally, so no beat is accepted behind a fail.
  - RUN→HALT: at the edge where a mismatch is recorded and HALT_ON_FAIL=1.
  - HALT: in_ready=0, halted=1. Any beat already in stage 1 still completes and is counted.
  - HALT→RUN: clear=1.
  - With HALT_ON_FAIL=0 the block never leaves RUN.
- clear: at the next edge, zero the counters, fail_sticky, capture registers and res_valid, and return state to RUN.
  - Beats in flight at that edge are dropped.
  - A beat accepted at the same edge as clear is also dropped.
  - clear has priority over a simultaneous count update.

Test Plan:
- a=FF b=01 cin=0 s=00 c=FF ovf=0 -> res_valid 2 cycles after accept, res_err=000, pass_count=1.
- a=7F b=01 cin=0 s=80 c=7F ovf=1 -> res_err=000; the same beat with ovf=0 -> res_err=100, fail_count=1, fail_sticky=1.
- a=80 b=01 cin=1 s=7E c=80 ovf=1 (expected s=7F) -> res_err=001, first_fail_a=80, first_fail_b=01, first_fail_cin=1; a later failing beat a=55 leaves the capture unchanged.
- HALT_ON_FAIL=1: stream beats 6C/CA/1 correct, then DD/09/1 with c wrong, then EF/11/0 -> in_ready drops while DD is in stage 1, EF is not accepted, halted=1, pass=1, fail=1; clear -> in_ready=1, counters 0.
- 8 correct beats back-to-back with in_valid held high -> one accept per cycle, 8 res_valid pulses on consecutive cycles, pass_count=8; CNT_W=2 run of 5 passes -> pass_count=3 (saturated).
- Assert rst asynchronously mid-cycle with 2 beats in flight -> all outputs 0 immediately, no res_valid after release, first beat after release is checked normally.
